// File: rtl/mips_mc_core.sv
// mips_mc_core: multicycle MIPS-subset core with a generic datapath width,
// a small register file and a stall-capable req/ready memory port.
module mips_mc_core #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] pc,
    output logic             instr_done,
    output logic             illegal
);
    localparam int BEATS = 32 / WIDTH;
    localparam int NREG  = 2 ** REGBITS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);
    localparam logic [BW-1:0]    LAST = BW'(BEATS - 1);

    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTEXEC, S_RTWB, S_ADDIEX, S_ADDIWB, S_BEQEX, S_JEX
    } state_t;

    state_t             r_state;
    logic [BW-1:0]      r_beat;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_aluout;
    logic [WIDTH-1:0]   r_mdr;
    logic [WIDTH-1:0]   r_adr;
    logic [WIDTH-1:0]   r_wdata;
    logic [31:0]        r_instr;
    logic [WIDTH-1:0]   r_rf [NREG];
    logic               r_req;
    logic               r_we;
    logic               r_done;
    logic               r_illegal;

    logic [5:0]         w_op;
    logic [5:0]         w_funct;
    logic [REGBITS-1:0] w_rs;
    logic [REGBITS-1:0] w_rt;
    logic [REGBITS-1:0] w_rd;
    logic [31:0]        w_sx;
    logic [31:0]        w_jfull;
    logic [WIDTH-1:0]   w_imm;
    logic [WIDTH-1:0]   w_boff;
    logic [WIDTH-1:0]   w_jt;
    logic [WIDTH-1:0]   w_addr;
    logic [WIDTH-1:0]   w_alu;
    logic               w_fok;
    logic [4:0]         w_lane;
    logic               w_unused;

    assign w_op    = r_instr[31:26];
    assign w_funct = r_instr[5:0];
    assign w_rs    = r_instr[21 +: REGBITS];
    assign w_rt    = r_instr[16 +: REGBITS];
    assign w_rd    = r_instr[11 +: REGBITS];
    assign w_sx    = {{16{r_instr[15]}}, r_instr[15:0]};
    assign w_imm   = w_sx[WIDTH-1:0];
    assign w_boff  = w_imm << 2;
    assign w_jfull = {4'b0000, r_instr[25:0], 2'b00};
    assign w_jt    = w_jfull[WIDTH-1:0];
    assign w_addr  = r_a + w_imm;
    // Beat 0 fills the most significant lane (big-endian instruction order).
    assign w_lane  = 5'(32 - WIDTH * (int'(r_beat) + 1));
    assign w_unused = ^{w_sx, w_jfull, r_instr};

    always_comb begin
        w_alu = '0;
        w_fok = 1'b1;
        unique case (w_funct)
            6'h20:   w_alu = r_a + r_b;
            6'h22:   w_alu = r_a - r_b;
            6'h24:   w_alu = r_a & r_b;
            6'h25:   w_alu = r_a | r_b;
            6'h2A:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            default: w_fok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_beat    <= '0;
            r_pc      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            r_adr     <= '0;
            r_wdata   <= '0;
            r_instr   <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                        r_we  <= 1'b0;
                        r_adr <= r_pc;
                    end else if (mem_ready) begin
                        r_instr[w_lane +: WIDTH] <= mem_rdata;
                        r_pc <= r_pc + STEP;
                        if (r_beat == LAST) begin
                            r_beat  <= '0;
                            r_req   <= 1'b0;
                            r_state <= S_DECODE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                            r_adr  <= r_pc + STEP;
                        end
                    end
                end
                S_DECODE: begin
                    r_a      <= r_rf[w_rs];
                    r_b      <= r_rf[w_rt];
                    r_aluout <= r_pc + w_boff;
                    case (w_op)
                        OP_RT:   r_state <= S_RTEXEC;
                        OP_LB:   r_state <= S_MEMADR;
                        OP_SB:   r_state <= S_MEMADR;
                        OP_ADDI: r_state <= S_ADDIEX;
                        OP_BEQ: begin
                            r_state <= S_BEQEX;
                            r_done  <= 1'b1;
                        end
                        OP_J: begin
                            r_state <= S_JEX;
                            r_done  <= 1'b1;
                        end
                        default: begin
                            r_illegal <= 1'b1;
                            r_state   <= S_FETCH;
                            r_req     <= 1'b1;
                            r_adr     <= r_pc;
                        end
                    endcase
                end
                S_MEMADR: begin
                    r_aluout <= w_addr;
                    r_adr    <= w_addr;
                    r_req    <= 1'b1;
                    r_wdata  <= r_b;
                    r_we     <= (w_op == OP_SB);
                    r_state  <= (w_op == OP_LB) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        r_mdr   <= mem_rdata;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    if (w_rt != '0) r_rf[w_rt] <= r_mdr;
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_adr   <= r_pc;
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        r_we    <= 1'b0;
                        r_adr   <= r_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_RTEXEC: begin
                    if (w_fok) begin
                        r_aluout <= w_alu;
                        r_done   <= 1'b1;
                        r_state  <= S_RTWB;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_FETCH;
                        r_req     <= 1'b1;
                        r_adr     <= r_pc;
                    end
                end
                S_RTWB: begin
                    if (w_rd != '0) r_rf[w_rd] <= r_aluout;
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_adr   <= r_pc;
                end
                S_ADDIEX: begin
                    r_aluout <= w_addr;
                    r_done   <= 1'b1;
                    r_state  <= S_ADDIWB;
                end
                S_ADDIWB: begin
                    if (w_rt != '0) r_rf[w_rt] <= r_aluout;
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_adr   <= r_pc;
                end
                S_BEQEX: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    if (r_a == r_b) begin
                        r_pc  <= r_aluout;
                        r_adr <= r_aluout;
                    end else begin
                        r_adr <= r_pc;
                    end
                end
                S_JEX: begin
                    r_pc    <= w_jt;
                    r_adr   <= w_jt;
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // A store retires in the cycle its write is accepted.
    assign instr_done = r_done | ((r_state == S_MEMWR) & r_req & mem_ready);
    assign illegal    = r_illegal;
    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_adr    = r_adr;
    assign mem_wdata  = r_wdata;
    assign pc         = r_pc;
endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: an 8-bit and a 16-bit instance, each
// against a small zero/stalled-wait memory model.
module tb_mips_mc_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, req8, we8, rdy8, done8, ill8;
    logic [7:0] adr8, wdata8, rdata8, pc8;
    logic [7:0] m8 [256];

    logic        rst16, req16, we16, rdy16, done16, ill16;
    logic [15:0] adr16, adr16p, wdata16, rdata16, pc16;
    logic [7:0]  m16 [1024];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int c;
    int w0;
    int wr_cnt8 = 0;
    logic [7:0] wr_adr8 = '0;
    logic [7:0] wr_data8 = '0;

    mips_mc_core #(.WIDTH(8), .REGBITS(3)) dut8 (
        .clk(clk), .reset(rst8),
        .mem_req(req8), .mem_we(we8), .mem_adr(adr8),
        .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ready(rdy8),
        .pc(pc8), .instr_done(done8), .illegal(ill8)
    );

    mips_mc_core #(.WIDTH(16), .REGBITS(3)) dut16 (
        .clk(clk), .reset(rst16),
        .mem_req(req16), .mem_we(we16), .mem_adr(adr16),
        .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(rdy16),
        .pc(pc16), .instr_done(done16), .illegal(ill16)
    );

    assign rdata8  = m8[adr8];
    assign adr16p  = adr16 + 16'd1;
    assign rdata16 = {m16[adr16[9:0]], m16[adr16p[9:0]]};

    always @(posedge clk) begin
        if (req8 && we8 && rdy8) begin
            wr_cnt8  <= wr_cnt8 + 1;
            wr_adr8  <= adr8;
            wr_data8 <= wdata8;
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load8(input int a, input logic [31:0] w);
        m8[a]   = w[31:24];
        m8[a+1] = w[23:16];
        m8[a+2] = w[15:8];
        m8[a+3] = w[7:0];
    endtask

    task automatic load16(input int a, input logic [31:0] w);
        m16[a]   = w[31:24];
        m16[a+1] = w[23:16];
        m16[a+2] = w[15:8];
        m16[a+3] = w[7:0];
    endtask

    task automatic restart8();
        rst8 = 1'b0;
        rdy8 = 1'b1;
        tick();
        tick();
        rst8 = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_done8(output int cy);
        cy = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done8 === 1'b1) begin
                cy = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done16(output int cy);
        cy = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done16 === 1'b1) begin
                cy = cyc;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m8[i] = 8'h00;
        for (int i = 0; i < 1024; i++) m16[i] = 8'h00;
        rst8 = 1'b0;
        rst16 = 1'b0;
        rdy8 = 1'b1;
        rdy16 = 1'b1;

        // ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SB r3,0x10(r0)
        load8(0, 32'h20010005);
        load8(4, 32'h2002FFFD);
        load8(8, 32'h00221820);
        load8(12, 32'hA0030010);
        tick();
        tick();
        chk("rst_pc", pc8, 0);
        chk("rst_req", req8, 0);
        chk("rst_we_done_ill", {we8, done8, ill8}, 0);
        w0 = wr_cnt8;
        rst8 = 1'b1;
        cyc = 0;
        tick();
        chk("fetch0_req_adr", {req8, adr8}, {1'b1, 8'h00});
        wait_done8(c);
        chk("done1_cyc", c, 7);
        wait_done8(c);
        chk("done2_cyc", c, 14);
        wait_done8(c);
        chk("done3_cyc", c, 21);
        wait_done8(c);
        chk("done4_cyc", c, 28);
        chk("sb_req_we", {req8, we8}, 2'b11);
        chk("sb_adr", adr8, 8'h10);
        chk("sb_wdata", wdata8, 8'h02);
        chk("pc_after4", pc8, 16);
        tick();
        chk("sb_count", wr_cnt8 - w0, 1);
        chk("sb_mem", {wr_adr8, wr_data8}, 16'h1002);

        // Stall three cycles on beat 2 of the first fetch
        restart8();
        tick();
        tick();
        tick();
        chk("stall_adr_c3", adr8, 8'h02);
        rdy8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold", {req8, we8, adr8}, {2'b10, 8'h02});
        end
        rdy8 = 1'b1;
        wait_done8(c);
        chk("stall_done1", c, 10);

        // ADDI r1,r0,5; J 0xF8; at 0xF8 BEQ r0,r0,+1 wraps to 0
        load8(4, 32'h0800003E);
        load8(248, 32'h10000001);
        restart8();
        wait_done8(c);
        chk("br_addi_cyc", c, 7);
        wait_done8(c);
        chk("j_cyc", c, 13);
        tick();
        chk("j_pc_adr", {pc8, adr8}, 16'hF8F8);
        wait_done8(c);
        chk("beq_cyc", c, 19);
        tick();
        chk("beq_wrap_pc", pc8, 8'h00);
        chk("beq_wrap_adr", adr8, 8'h00);

        // BEQ r1,r0,+1 with r1=5 falls through
        load8(248, 32'h10200001);
        restart8();
        wait_done8(c);
        wait_done8(c);
        wait_done8(c);
        chk("beqn_cyc", c, 19);
        tick();
        chk("beqn_pc", pc8, 8'hFC);

        // Opcode 111111, then SB r1,0x20(r0) to show r1 stayed 0
        load8(0, 32'hFC210000);
        load8(4, 32'hA0010020);
        w0 = wr_cnt8;
        restart8();
        for (int k = 0; k < 5; k++) tick();
        chk("ill_early", ill8, 0);
        tick();
        chk("ill_pulse", {ill8, done8}, 2'b10);
        chk("ill_next", {req8, we8, adr8}, {2'b10, 8'h04});
        tick();
        chk("ill_single", ill8, 0);
        wait_done8(c);
        chk("ill_sb_cyc", c, 12);
        chk("ill_sb_data", {adr8, wdata8}, 16'h2000);
        tick();
        chk("ill_wr_count", wr_cnt8 - w0, 1);

        // Reset while beat 1 is in flight
        restart8();
        tick();
        tick();
        chk("mid_beat1", {req8, adr8, pc8}, {1'b1, 8'h01, 8'h01});
        rst8 = 1'b0;
        tick();
        chk("mid_rst_req", req8, 0);
        chk("mid_rst_pc", pc8, 0);

        // WIDTH=16: LB r1,0x100(r0); SB r1,0x200(r0)
        load16(0, 32'h80010100);
        load16(4, 32'hA0010200);
        m16[256] = 8'hBE;
        m16[257] = 8'hEF;
        tick();
        chk("w16_rst", {req16, pc16}, 0);
        rst16 = 1'b1;
        cyc = 0;
        tick();
        chk("w16_beat0", {req16, adr16}, {1'b1, 16'h0000});
        tick();
        chk("w16_beat1", {req16, adr16}, {1'b1, 16'h0002});
        tick();
        tick();
        tick();
        chk("w16_lb_req", {req16, we16, adr16}, {2'b10, 16'h0100});
        wait_done16(c);
        chk("w16_lb_cyc", c, 6);
        wait_done16(c);
        chk("w16_sb_cyc", c, 11);
        chk("w16_sb", {we16, adr16, wdata16}, {1'b1, 16'h0200, 16'hBEEF});
        chk("w16_pc", pc16, 16'h0008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
